// File: rtl/pipe_step_ctrl_pkg.sv
// Shared types and defaults for the pipeline step/run controller.
// FSM encodings are fixed because the display decodes the raw state value.
package pipe_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam int unsigned RUN_DIV_DEFAULT = 25000;
  localparam int unsigned CNT_W_DEFAULT   = 8;

  // Divider counts 0..div-1, so it needs clog2(div) bits, never fewer than one.
  function automatic int unsigned div_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/pipe_step_ctrl_if.sv
// Bundle of the controller's user/CPU-facing signals; clock and reset stay outside.
// master = stimulus/CPU side, slave = pipe_step_ctrl.
interface pipe_step_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             step_btn;
  logic             run_sw;
  logic             brk_en;
  logic [31:0]      brk_pc;
  logic [31:0]      if_pc;
  logic             pipe_en;
  logic             lcd_refresh;
  logic [CNT_W-1:0] cyc_cnt;
  logic             halted;
  logic [1:0]       state;

  modport master (
    output step_btn, run_sw, brk_en, brk_pc, if_pc,
    input  pipe_en, lcd_refresh, cyc_cnt, halted, state
  );

  modport slave (
    input  step_btn, run_sw, brk_en, brk_pc, if_pc,
    output pipe_en, lcd_refresh, cyc_cnt, halted, state
  );
endinterface

// File: rtl/pipe_step_ctrl_sync_edge.sv
// Two-flop synchroniser with a rising-edge detector for an asynchronous level.
// A level already high when reset releases is taken as the baseline, not an edge.
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic [1:0] arm_q;

  // Until armed, prev_q follows the first flop so it already holds whatever the
  // second flop is about to show, which hides a level present at reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      arm_q  <= 2'b00;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      arm_q  <= {arm_q[0], 1'b1};
      prev_q <= arm_q[1] ? sync_q : meta_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q & arm_q[1];

endmodule

// File: rtl/pipe_step_ctrl.sv
// Single-step / free-run / breakpoint controller producing the pipeline advance pulse.
// Define PIPE_STEP_BRK_EN to compile in the breakpoint compare and the HALT state.
module pipe_step_ctrl
  import pipe_step_ctrl_pkg::*;
#(
  parameter int unsigned RUN_DIV = RUN_DIV_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic            CCLK,
  input  logic            rst_n,
  pipe_step_ctrl_if.slave bus
);

  localparam int unsigned      DIV_W    = div_width(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  logic step_evt;
  logic run_lvl;
  logic step_unused_lvl;
  logic run_unused_rise;
  logic brk_hit;

  state_e           state_q,   state_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic             pipe_en_q, pipe_en_d;
  logic             lcd_q,     lcd_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             halted_q,  halted_d;
  logic             boot_q;

  sync_edge u_step_sync (
    .clk_i   (CCLK),
    .rst_ni  (rst_n),
    .d_i     (bus.step_btn),
    .level_o (step_unused_lvl),
    .rise_o  (step_evt)
  );

  sync_edge u_run_sync (
    .clk_i   (CCLK),
    .rst_ni  (rst_n),
    .d_i     (bus.run_sw),
    .level_o (run_lvl),
    .rise_o  (run_unused_rise)
  );

`ifdef PIPE_STEP_BRK_EN
  assign brk_hit = bus.brk_en && (bus.if_pc == bus.brk_pc);
`else
  logic brk_unused;
  assign brk_unused = bus.brk_en ^ (^bus.brk_pc) ^ (^bus.if_pc);
  assign brk_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pipe_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_lvl) begin
          state_d = ST_RUN;
        end else if (step_evt) begin
          state_d   = ST_STEP;
          pipe_en_d = 1'b1;
        end
      end
      ST_STEP: begin
        state_d = ST_IDLE;
      end
      ST_RUN: begin
        // Dropping run_sw beats a wrap in the same cycle: no late pulse escapes.
        if (!run_lvl) begin
          state_d = ST_IDLE;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (brk_hit) begin
            state_d = ST_HALT;
          end else begin
            pipe_en_d = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`ifdef PIPE_STEP_BRK_EN
      ST_HALT: begin
        // Steps taken here skip the breakpoint compare so execution can move past it.
        if (!run_lvl) begin
          state_d = ST_IDLE;
        end else if (step_evt) begin
          pipe_en_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
      end
    endcase
  end

  always_comb begin
    lcd_d = pipe_en_q | ~boot_q;
    cnt_d = cnt_q + CNT_W'(pipe_en_q);
`ifdef PIPE_STEP_BRK_EN
    halted_d = (state_d == ST_HALT);
`else
    halted_d = 1'b0;
`endif
  end

  // boot_q marks the first cycle after reset release so the display repaints once.
  always_ff @(posedge CCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      pipe_en_q <= 1'b0;
      lcd_q     <= 1'b0;
      cnt_q     <= '0;
      halted_q  <= 1'b0;
      boot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pipe_en_q <= pipe_en_d;
      lcd_q     <= lcd_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      boot_q    <= 1'b1;
    end
  end

  assign bus.pipe_en     = pipe_en_q;
  assign bus.lcd_refresh = lcd_q;
  assign bus.cyc_cnt     = cnt_q;
  assign bus.halted      = halted_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Directed bench for pipe_step_ctrl with RUN_DIV=4, CNT_W=8.
// Breakpoint expectations follow whether PIPE_STEP_BRK_EN is defined.
module tb_pipe_step_ctrl;

  localparam int unsigned RUN_DIV = 4;
  localparam int unsigned CNT_W   = 8;

  logic CCLK = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  pipe_step_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_step_ctrl #(
    .RUN_DIV (RUN_DIV),
    .CNT_W   (CNT_W)
  ) dut (
    .CCLK  (CCLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 CCLK = ~CCLK;

  // Fetch PC advances one word per issued pipeline step.
  always_comb bus.if_pc = 32'({bus.cyc_cnt, 2'b00});

  task automatic tick();
    @(posedge CCLK);
    #1;
  endtask

  task automatic apply_reset();
    rst_n        = 1'b0;
    bus.step_btn = 1'b0;
    bus.run_sw   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    int pulses;
    rst_n        = 1'b0;
    bus.step_btn = 1'b1;
    bus.run_sw   = 1'b0;
    bus.brk_en   = 1'b0;
    bus.brk_pc   = 32'h0;
    tick();
    tick();
    checks++;
    if ({bus.pipe_en, bus.lcd_refresh, bus.halted} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got pe=%0b lcd=%0b halt=%0b, expected all 0",
               bus.pipe_en, bus.lcd_refresh, bus.halted);
    end
    checks++;
    if ({bus.cyc_cnt, bus.state} !== 10'd0) begin
      errors++;
      $display("FAIL reset_cnt_state: got cnt=%0d state=%0d, expected 0/0", bus.cyc_cnt, bus.state);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.lcd_refresh !== 1'b1) begin
      errors++;
      $display("FAIL boot_refresh: got %0b expected 1", bus.lcd_refresh);
    end
    tick();
    checks++;
    if (bus.lcd_refresh !== 1'b0) begin
      errors++;
      $display("FAIL boot_refresh_width: got %0b expected 0", bus.lcd_refresh);
    end
    pulses = 0;
    repeat (8) begin
      tick();
      if (bus.pipe_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || bus.state !== 2'd0) begin
      errors++;
      $display("FAIL btn_high_at_release: got pulses=%0d state=%0d expected 0/0", pulses, bus.state);
    end
    bus.step_btn = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_single_step();
    apply_reset();
    bus.step_btn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (bus.pipe_en !== ((i == 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL step_pe_c%0d: got %0b expected %0b", i, bus.pipe_en, (i == 3));
      end
      if (i == 3) begin
        checks++;
        if (bus.state !== 2'd1) begin
          errors++;
          $display("FAIL step_state: got %0d expected 1", bus.state);
        end
      end
      if (i == 4) begin
        checks++;
        if (bus.lcd_refresh !== 1'b1 || bus.cyc_cnt !== 8'd1 || bus.state !== 2'd0) begin
          errors++;
          $display("FAIL step_after: got lcd=%0b cnt=%0d state=%0d expected 1/1/0",
                   bus.lcd_refresh, bus.cyc_cnt, bus.state);
        end
      end
    end
    bus.step_btn = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_free_run();
    int pulses, first, last, gap_bad, lcd_bad;
    logic prev_pe;
    apply_reset();
    pulses = 0; first = -1; last = -1; gap_bad = 0; lcd_bad = 0; prev_pe = 1'b0;
    bus.run_sw = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 20) bus.step_btn = 1'b1;
      if (i == 30) bus.step_btn = 1'b0;
      tick();
      if (bus.pipe_en === 1'b1) begin
        pulses++;
        if (last >= 0 && (i - last) != RUN_DIV) gap_bad++;
        if (first < 0) first = i;
        last = i;
      end
      if (bus.lcd_refresh !== prev_pe) lcd_bad++;
      prev_pe = bus.pipe_en;
    end
    checks++;
    if (first !== 7) begin
      errors++;
      $display("FAIL run_first_pulse: got cycle %0d expected 7", first);
    end
    checks++;
    if (pulses !== 9 || gap_bad !== 0) begin
      errors++;
      $display("FAIL run_pulses: got %0d pulses, %0d bad gaps, expected 9/0", pulses, gap_bad);
    end
    checks++;
    if (lcd_bad !== 0) begin
      errors++;
      $display("FAIL run_lcd_follow: got %0d misplaced refreshes expected 0", lcd_bad);
    end
    checks++;
    if (bus.cyc_cnt !== 8'd9) begin
      errors++;
      $display("FAIL run_cnt: got %0d expected 9", bus.cyc_cnt);
    end
    bus.run_sw = 1'b0;
    pulses = 0;
    repeat (10) begin
      tick();
      if (bus.pipe_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || bus.state !== 2'd0) begin
      errors++;
      $display("FAIL run_stop: got pulses=%0d state=%0d expected 0/0", pulses, bus.state);
    end
  endtask

  task automatic test_simultaneous_and_reset();
    int pulses;
    apply_reset();
    pulses = 0;
    bus.run_sw   = 1'b1;
    bus.step_btn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (bus.pipe_en === 1'b1) pulses++;
      if (i == 3) begin
        checks++;
        if (bus.state !== 2'd2) begin
          errors++;
          $display("FAIL simul_state: got %0d expected 2", bus.state);
        end
      end
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL simul_no_step: got %0d pulses expected 0", pulses);
    end
    tick();
    checks++;
    if (bus.pipe_en !== 1'b1) begin
      errors++;
      $display("FAIL simul_run_pulse: got %0b expected 1", bus.pipe_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.pipe_en, bus.lcd_refresh, bus.halted, bus.cyc_cnt, bus.state} !== 13'd0) begin
      errors++;
      $display("FAIL midrun_reset: got pe=%0b lcd=%0b halt=%0b cnt=%0d state=%0d expected all 0",
               bus.pipe_en, bus.lcd_refresh, bus.halted, bus.cyc_cnt, bus.state);
    end
    bus.run_sw   = 1'b0;
    bus.step_btn = 1'b0;
    tick();
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      tick();
      if (bus.pipe_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || bus.state !== 2'd0 || bus.cyc_cnt !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_quiet: got pulses=%0d state=%0d cnt=%0d expected 0/0/0",
               pulses, bus.state, bus.cyc_cnt);
    end
  endtask

  task automatic test_wrap();
    int pulses;
    apply_reset();
    pulses = 0;
    for (int s = 0; s < 256; s++) begin
      bus.step_btn = 1'b1;
      repeat (4) begin
        tick();
        if (bus.pipe_en === 1'b1) pulses++;
      end
      bus.step_btn = 1'b0;
      repeat (3) begin
        tick();
        if (bus.pipe_en === 1'b1) pulses++;
      end
      if (s == 254) begin
        checks++;
        if (bus.cyc_cnt !== 8'hFF) begin
          errors++;
          $display("FAIL wrap_ff: got 0x%0h expected 0xff", bus.cyc_cnt);
        end
      end
    end
    checks++;
    if (pulses !== 256 || bus.cyc_cnt !== 8'h00) begin
      errors++;
      $display("FAIL wrap_zero: got pulses=%0d cnt=0x%0h expected 256/0x0", pulses, bus.cyc_cnt);
    end
  endtask

  task automatic test_breakpoint();
    int pulses;
    apply_reset();
    bus.brk_en = 1'b1;
    bus.brk_pc = 32'h0000_000C;
    bus.run_sw = 1'b1;
    pulses = 0;
    repeat (22) begin
      tick();
      if (bus.pipe_en === 1'b1) pulses++;
    end
`ifdef PIPE_STEP_BRK_EN
    checks++;
    if (pulses !== 3 || bus.cyc_cnt !== 8'd3) begin
      errors++;
      $display("FAIL brk_pulses: got pulses=%0d cnt=%0d expected 3/3", pulses, bus.cyc_cnt);
    end
    checks++;
    if (bus.state !== 2'd3 || bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL brk_halt: got state=%0d halted=%0b expected 3/1", bus.state, bus.halted);
    end
    bus.step_btn = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (bus.pipe_en === 1'b1) pulses++;
      if (i == 3) begin
        checks++;
        if (bus.pipe_en !== 1'b1 || bus.state !== 2'd3 || bus.halted !== 1'b1) begin
          errors++;
          $display("FAIL halt_step: got pe=%0b state=%0d halted=%0b expected 1/3/1",
                   bus.pipe_en, bus.state, bus.halted);
        end
      end
    end
    bus.step_btn = 1'b0;
    repeat (8) begin
      tick();
      if (bus.pipe_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1 || bus.cyc_cnt !== 8'd4 || bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_single: got pulses=%0d cnt=%0d halted=%0b expected 1/4/1",
               pulses, bus.cyc_cnt, bus.halted);
    end
    bus.run_sw = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.state !== 2'd0 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_exit: got state=%0d halted=%0b expected 0/0", bus.state, bus.halted);
    end
`else
    checks++;
    if (pulses !== 4 || bus.cyc_cnt !== 8'd4) begin
      errors++;
      $display("FAIL nobrk_pulses: got pulses=%0d cnt=%0d expected 4/4", pulses, bus.cyc_cnt);
    end
    checks++;
    if (bus.state !== 2'd2 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL nobrk_state: got state=%0d halted=%0b expected 2/0", bus.state, bus.halted);
    end
    bus.run_sw = 1'b0;
    repeat (4) tick();
`endif
    bus.brk_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.step_btn = 1'b0;
    bus.run_sw   = 1'b0;
    bus.brk_en   = 1'b0;
    bus.brk_pc   = 32'h0;
    test_reset();
    test_single_step();
    test_free_run();
    test_simultaneous_and_reset();
    test_breakpoint();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_step_ctrl.md
PIPE_STEP_CTRL -- requirements
Module: pipe_step_ctrl

Interface
- REQ-001 SHALL have parameter RUN_DIV, default 25000: CCLK cycles between free-run advance pulses; legal range 2..2^20.
- REQ-002 SHALL have parameter CNT_W, default 8: width of the cycle counter.
- REQ-003 SHALL have port CCLK, input, 1: single system clock; all logic is on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
- REQ-005 SHALL have port step_btn, input, 1: debounced step button level; asynchronous to CCLK.
- REQ-006 SHALL have port run_sw, input, 1: free-run request level; asynchronous to CCLK.
- REQ-007 SHALL have port brk_en, input, 1: breakpoint enable.
- REQ-008 SHALL have port brk_pc, input, 32: breakpoint address.
- REQ-009 SHALL have port if_pc, input, 32: current fetch PC from the IF stage.
- REQ-010 SHALL have port pipe_en, output, 1: one-cycle pulse that advances every pipeline stage by one.
- REQ-011 SHALL have port lcd_refresh, output, 1: one-cycle pulse requesting a display update.
- REQ-012 SHALL have port cyc_cnt, output, CNT_W: count of issued pipe_en pulses.
- REQ-013 SHALL have port halted, output, 1: high while in HALT.
- REQ-014 SHALL have port state, output, 2: FSM state encoding, for the display.

Function
- REQ-015 SHALL pass step_btn and run_sw through 2-flop synchronisers before any use.
- REQ-016 SHALL form step_evt as a 1-cycle pulse on each rising edge of the synchronised step_btn.
- REQ-017 SHALL implement FSM states IDLE=0, STEP=1, RUN=2, HALT=3.
- REQ-018 In IDLE:
  - If synchronised run_sw=1, SHALL go to RUN; this takes priority over a same-cycle step_evt, which is dropped.
  - Otherwise, on step_evt SHALL go to STEP.
- REQ-019 STEP SHALL last exactly one cycle, assert pipe_en in that cycle, then return to IDLE.
- REQ-020 In RUN:
  - SHALL count a divider 0..RUN_DIV-1 and assert pipe_en in the cycle the divider wraps to 0.
  - SHALL ignore step_evt.
- REQ-021 In RUN, if run_sw=0, SHALL go to IDLE at once, clear the divider and issue no further pulse.
- REQ-022 In RUN at a wrap cycle, if brk_en=1 and if_pc==brk_pc, SHALL suppress pipe_en and go to HALT.
- REQ-023 In HALT:
  - On step_evt, SHALL assert pipe_en for one cycle and remain in HALT (step past the breakpoint).
  - If run_sw=0, SHALL go to IDLE.
  - The breakpoint check SHALL NOT apply to HALT steps.
- REQ-024 SHALL assert lcd_refresh exactly one cycle after every pipe_en, and for one cycle on the cycle after reset release.
- REQ-025 SHALL increment cyc_cnt by 1 in the cycle after each pipe_en, wrapping from all-ones to 0 without flagging.
- REQ-026 SHALL keep pipe_en at most one cycle wide and never assert it in two consecutive cycles.
- REQ-027 SHALL keep halted equal to (state==HALT), registered.

Reset
- REQ-028 While rst_n=0, the block SHALL hold:
  - state=IDLE
  - pipe_en=0, lcd_refresh=0, cyc_cnt=0, halted=0
  - divider=0, synchronisers=0
- REQ-029 Reset asserted mid-RUN or mid-STEP SHALL abort any pending pulse; no pipe_en SHALL follow reset release without a new request.
- REQ-030 A step_btn already high at reset release SHALL NOT create step_evt.

Configuration
- REQ-031 With macro PIPE_STEP_BRK_EN defined:
  - breakpoint compare and the HALT state SHALL be compiled in as specified.
- REQ-032 Without PIPE_STEP_BRK_EN:
  - brk_en, brk_pc and if_pc SHALL be ignored and HALT SHALL be unreachable.
  - halted SHALL be tied to 0.
  - Port list SHALL be unchanged.

Structure
- REQ-033 Shared package SHALL hold the state typedef/encodings (IDLE/STEP/RUN/HALT) and the default RUN_DIV constant.
- REQ-034 The synchroniser-plus-rising-edge detector SHALL be a sub-module named sync_edge, instantiated twice (step_evt uses its edge output; run_sw uses its level output).

Verification
- REQ-035 Single step: from IDLE, raise step_btn → exactly one pipe_en 3 cycles later, lcd_refresh one cycle after that, cyc_cnt 0→1.
- REQ-036 Free run: RUN_DIV=4, run_sw=1 for 40 cycles → pipe_en every 4th cycle; cyc_cnt steps by one per pulse (≈9–10 total); run_sw=0 → pulses stop within 3 cycles.
- REQ-037 Breakpoint (macro defined): brk_en=1, brk_pc=0x0000000C, if_pc reaches 0x0C at a wrap → no pipe_en, halted=1; a step_evt then gives one pipe_en and halted stays 1.
- REQ-038 Wrap-around: CNT_W=8, issue 256 steps → cyc_cnt returns to 0x00.
- REQ-039 Simultaneous events and reset:
  - run_sw and step_btn rising in the same cycle from IDLE → RUN entered, no STEP pulse.
  - rst_n pulled low mid-RUN → all outputs 0 immediately; state=IDLE after release.
